// File: rtl/square_accumulator.sv
// Sequential squarer: square = n*n, built by summing the first n odd numbers.
// Counterpart of the square-root unit, which subtracts the same odd series.
// One addition per clock; an operation on operand k takes k+2 cycles from start to IDLE.
module square_accumulator #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     n_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   square_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // The odd term needs WIDTH+1 bits: its largest value added is 2*(2^WIDTH-1)-1.
    // The accumulator cannot overflow since (2^WIDTH-1)^2 < 2^(2*WIDTH).
    logic [1:0]           state_q,  state_d;
    logic [WIDTH-1:0]     count_q,  count_d;
    logic [WIDTH:0]       odd_q,    odd_d;
    logic [2*WIDTH-1:0]   square_q, square_d;

    // Odd term zero-extended to the accumulator width.
    logic [2*WIDTH-1:0]   odd_ext;
    assign odd_ext = {{(WIDTH-1){1'b0}}, odd_q};

    // Next-state and datapath: capture on accepted start, add one odd term per ACCUM cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        odd_d    = odd_q;
        square_d = square_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    count_d  = n_i;
                    odd_d    = {{WIDTH{1'b0}}, 1'b1};
                    square_d = '0;
                    // A zero operand has nothing to add and reports immediately.
                    state_d  = (n_i != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                square_d = square_q + odd_ext;
                odd_d    = odd_q + {{(WIDTH-1){1'b0}}, 2'd2};
                count_d  = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
                if (count_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Result stays in square_q through IDLE until the next start.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            odd_q    <= {{WIDTH{1'b0}}, 1'b1};
            square_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            odd_q    <= odd_d;
            square_q <= square_d;
        end
    end

    // Moore outputs decoded straight from the state register.
    assign ready_o  = (state_q == ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign square_o = square_q;

endmodule

// File: tb/tb_square_accumulator.sv
// Self-checking bench for square_accumulator (WIDTH=8).
// Table-driven operations plus hand-written multi-cycle sequences; results are
// pushed to a scoreboard at start and popped by a monitor when done_o appears.
module tb_square_accumulator;

    localparam int WIDTH = 8;

    logic                clk;
    logic                rst;
    logic                start_i;
    logic [WIDTH-1:0]    n_i;
    logic                ready_o;
    logic                done_o;
    logic [2*WIDTH-1:0]  square_o;

    int checks_total;
    int checks_passed;

    logic [31:0] sb_q[$];

    typedef struct {
        logic [WIDTH-1:0] n;
        logic [31:0]      exp_sq;
        int               exp_lat;
    } vec_t;

    vec_t vecs[10];

    square_accumulator #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .n_i      (n_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .square_o (square_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done_o pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("sb_square", {16'd0, square_o}, sb_q.pop_front());
            end
        end
    end

    // Must be called at a negedge with the DUT idle. Returns at the negedge after done.
    task automatic run_op(input logic [WIDTH-1:0] n, input logic [31:0] exp_sq, input int exp_lat);
        int j;
        bit seen;
        check("ready_before_start", {31'd0, ready_o}, 32'd1);
        n_i     = n;
        start_i = 1'b1;
        sb_q.push_back(exp_sq);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        n_i     = $urandom_range(0, 255);
        seen = 1'b0;
        j = 0;
        while (!seen && j <= exp_lat + 20) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
            else j++;
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end else begin
            check("latency", j, exp_lat);
            @(negedge clk);
            check("ready_after", {31'd0, ready_o}, 32'd1);
            check("done_after", {31'd0, done_o}, 32'd0);
            check("square_held", {16'd0, square_o}, exp_sq);
        end
        $display("op n=%0d square=%0d latency=%0d", n, square_o, j);
    endtask

    initial begin
        int j;
        logic [WIDTH-1:0] rn;
        checks_total  = 0;
        checks_passed = 0;
        rst     = 1'b1;
        start_i = 1'b0;
        n_i     = '0;

        vecs[0] = '{n: 8'd0,   exp_sq: 32'd0,     exp_lat: 0};
        vecs[1] = '{n: 8'd1,   exp_sq: 32'd1,     exp_lat: 1};
        vecs[2] = '{n: 8'd255, exp_sq: 32'd65025, exp_lat: 255};
        vecs[3] = '{n: 8'd3,   exp_sq: 32'd9,     exp_lat: 3};
        vecs[4] = '{n: 8'd7,   exp_sq: 32'd49,    exp_lat: 7};
        vecs[5] = '{n: 8'd12,  exp_sq: 32'd144,   exp_lat: 12};
        vecs[6] = '{n: 8'd100, exp_sq: 32'd10000, exp_lat: 100};
        vecs[7] = '{n: 8'd200, exp_sq: 32'd40000, exp_lat: 200};
        vecs[8] = '{n: 8'd16,  exp_sq: 32'd256,   exp_lat: 16};
        vecs[9] = '{n: 8'd2,   exp_sq: 32'd4,     exp_lat: 2};

        // Reset then idle.
        #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("idle_ready", {31'd0, ready_o}, 32'd1);
            check("idle_done", {31'd0, done_o}, 32'd0);
            check("idle_square", {16'd0, square_o}, 32'd0);
        end

        // Zero operand: done in the very next cycle.
        n_i = 8'd0;
        start_i = 1'b1;
        sb_q.push_back(32'd0);
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        check("zero_ready", {31'd0, ready_o}, 32'd0);
        check("zero_done", {31'd0, done_o}, 32'd1);
        check("zero_square", {16'd0, square_o}, 32'd0);
        @(negedge clk);
        check("zero_ready_after", {31'd0, ready_o}, 32'd1);
        check("zero_done_after", {31'd0, done_o}, 32'd0);
        $display("op n=0 zero-operand sequence");

        // Nominal n=5: partial sums 1,4,9,16,25 after edges 1..5.
        n_i = 8'd5;
        start_i = 1'b1;
        sb_q.push_back(32'd25);
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        check("n5_edge0_square", {16'd0, square_o}, 32'd0);
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            check("n5_partial", {16'd0, square_o}, e * e);
            check("n5_done_level", {31'd0, done_o}, (e == 5) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("n5_held", {16'd0, square_o}, 32'd25);
        check("n5_ready", {31'd0, ready_o}, 32'd1);
        $display("op n=5 nominal sequence square=%0d", square_o);

        // Table-driven operations.
        foreach (vecs[i]) run_op(vecs[i].n, vecs[i].exp_sq, vecs[i].exp_lat);

        // Random operations, expected value from a multiply model.
        for (int r = 0; r < 4; r++) begin
            rn = $urandom_range(0, 60);
            run_op(rn, rn * rn, int'(rn));
        end

        // Busy protection: a start with n=7 during ACCUM is ignored.
        n_i = 8'd3;
        start_i = 1'b1;
        sb_q.push_back(32'd9);
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_i = 8'd7;
        start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        check("busy_no_done_edge2", {31'd0, done_o}, 32'd0);
        check("busy_partial_edge2", {16'd0, square_o}, 32'd4);
        @(negedge clk);
        check("busy_done_edge3", {31'd0, done_o}, 32'd1);
        check("busy_square", {16'd0, square_o}, 32'd9);
        @(negedge clk);
        $display("op n=3 busy-protection square=%0d", square_o);
        run_op(8'd7, 32'd49, 7);

        // Reset mid-operation: n=10 abandoned between edges 4 and 5.
        n_i = 8'd10;
        start_i = 1'b1;
        sb_q.push_back(32'd100);
        @(posedge clk); #1 start_i = 1'b0;
        for (int e = 0; e <= 4; e++) @(negedge clk);
        check("abort_partial", {16'd0, square_o}, 32'd16);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("abort_square", {16'd0, square_o}, 32'd0);
        check("abort_ready", {31'd0, ready_o}, 32'd1);
        check("abort_done", {31'd0, done_o}, 32'd0);
        #2 rst = 1'b0;
        j = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done_o) j++;
        end
        check("abort_no_done", j, 0);
        $display("op n=10 reset-abort, done pulses afterwards=%0d", j);
        run_op(8'd4, 32'd16, 4);

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
